// File: rtl/ifetch_unit.sv
// Instruction fetch unit: tracks the fetch PC, issues one-word requests to the
//   memory controller, pre-classifies returned words and queues them for decode.
// Latency: a word returned at edge N is dispatched (if_to_dc_ready=1) after edge
//   N+1 when the queue was empty and decode is not stalled.
// Backpressure: rob_full/rs_full block the pop; a full queue blocks new requests;
//   rdy_in low freezes everything.
//
// Ports:
//   clk_in, rst_in (sync, active-low), rdy_in (global enable)
//   rob_full, rs_full              : dispatch stalls
//   rob_to_if_jump_en/_addr        : redirect + flush
//   if_to_mc_en/_PC, mc_to_if_*    : memory request / single-cycle response
//   if_to_dc_*                     : registered dispatch bundle to decode
module ifetch_unit #(
  parameter int          IQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_full,
  input  logic        rs_full,
  input  logic        rob_to_if_jump_en,
  input  logic [31:0] rob_to_if_jump_addr,
  output logic        if_to_mc_en,
  output logic [31:0] if_to_mc_PC,
  input  logic        mc_to_if_ready,
  input  logic [31:0] mc_to_if_inst,
  output logic        if_to_dc_ready,
  output logic [31:0] if_to_dc_PC,
  output logic [31:0] if_to_dc_inst,
  output logic [3:0]  if_to_dc_opType,
  output logic [5:0]  if_to_dc_op
);

  localparam int PW = $clog2(IQ_DEPTH);
  localparam logic [PW:0] IQ_FULL = (PW+1)'(IQ_DEPTH);

  // Opcode classes (0 = unknown opcode)
  localparam logic [3:0] OP_LUI = 4'd1, OP_AUIPC = 4'd2, OP_JAL = 4'd3,
                         OP_JALR = 4'd4, OP_BR = 4'd5, OP_LD = 4'd6,
                         OP_ST = 4'd7, OP_RI = 4'd8, OP_RC = 4'd9;

  // Operations (0 = none / invalid funct3)
  localparam logic [5:0]
    E_LUI = 6'd1,  E_AUIPC = 6'd2, E_JAL = 6'd3,  E_JALR = 6'd4,
    E_BEQ = 6'd5,  E_BNE = 6'd6,   E_BLT = 6'd7,  E_BGE = 6'd8,
    E_BLTU = 6'd9, E_BGEU = 6'd10, E_LB = 6'd11,  E_LH = 6'd12,
    E_LW = 6'd13,  E_LBU = 6'd14,  E_LHU = 6'd15, E_SB = 6'd16,
    E_SH = 6'd17,  E_SW = 6'd18,   E_ADDI = 6'd19, E_SLTI = 6'd20,
    E_SLTIU = 6'd21, E_XORI = 6'd22, E_ORI = 6'd23, E_ANDI = 6'd24,
    E_SLLI = 6'd25, E_SRLI = 6'd26, E_SRAI = 6'd27, E_ADD = 6'd28,
    E_SUB = 6'd29, E_SLL = 6'd30,  E_SLT = 6'd31, E_SLTU = 6'd32,
    E_XOR = 6'd33, E_SRL = 6'd34,  E_SRA = 6'd35, E_OR = 6'd36,
    E_AND = 6'd37;

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;

  logic [31:0] iq_pc   [IQ_DEPTH];
  logic [31:0] iq_inst [IQ_DEPTH];
  logic [3:0]  iq_type [IQ_DEPTH];
  logic [5:0]  iq_op   [IQ_DEPTH];

  // Pre-decode of the word arriving from memory
  logic [3:0]  pd_type;
  logic [5:0]  pd_op;
  logic [2:0]  f3;
  logic        f7b5;
  logic [31:0] jal_imm;
  logic [31:0] next_pc;

  assign f3      = mc_to_if_inst[14:12];
  assign f7b5    = mc_to_if_inst[30];
  assign jal_imm = {{12{mc_to_if_inst[31]}}, mc_to_if_inst[19:12],
                    mc_to_if_inst[20], mc_to_if_inst[30:21], 1'b0};
  // Only JAL is predicted; JALR and branches fall through.
  assign next_pc = (mc_to_if_inst[6:0] == 7'b1101111) ? pc + jal_imm : pc + 32'd4;

  always_comb begin
    pd_type = 4'd0;
    pd_op   = 6'd0;
    case (mc_to_if_inst[6:0])
      7'b0110111: begin pd_type = OP_LUI;   pd_op = E_LUI;   end
      7'b0010111: begin pd_type = OP_AUIPC; pd_op = E_AUIPC; end
      7'b1101111: begin pd_type = OP_JAL;   pd_op = E_JAL;   end
      7'b1100111: begin pd_type = OP_JALR;  pd_op = E_JALR;  end
      7'b1100011: begin
        pd_type = OP_BR;
        case (f3)
          3'b000: pd_op = E_BEQ;
          3'b001: pd_op = E_BNE;
          3'b100: pd_op = E_BLT;
          3'b101: pd_op = E_BGE;
          3'b110: pd_op = E_BLTU;
          3'b111: pd_op = E_BGEU;
          default: pd_op = 6'd0;
        endcase
      end
      7'b0000011: begin
        pd_type = OP_LD;
        case (f3)
          3'b000: pd_op = E_LB;
          3'b001: pd_op = E_LH;
          3'b010: pd_op = E_LW;
          3'b100: pd_op = E_LBU;
          3'b101: pd_op = E_LHU;
          default: pd_op = 6'd0;
        endcase
      end
      7'b0100011: begin
        pd_type = OP_ST;
        case (f3)
          3'b000: pd_op = E_SB;
          3'b001: pd_op = E_SH;
          3'b010: pd_op = E_SW;
          default: pd_op = 6'd0;
        endcase
      end
      7'b0010011: begin
        pd_type = OP_RI;
        case (f3)
          3'b000: pd_op = E_ADDI;
          3'b010: pd_op = E_SLTI;
          3'b011: pd_op = E_SLTIU;
          3'b100: pd_op = E_XORI;
          3'b110: pd_op = E_ORI;
          3'b111: pd_op = E_ANDI;
          3'b001: pd_op = E_SLLI;
          default: pd_op = f7b5 ? E_SRAI : E_SRLI;
        endcase
      end
      7'b0110011: begin
        pd_type = OP_RC;
        case (f3)
          3'b000: pd_op = f7b5 ? E_SUB : E_ADD;
          3'b001: pd_op = E_SLL;
          3'b010: pd_op = E_SLT;
          3'b011: pd_op = E_SLTU;
          3'b100: pd_op = E_XOR;
          3'b101: pd_op = f7b5 ? E_SRA : E_SRL;
          3'b110: pd_op = E_OR;
          default: pd_op = E_AND;
        endcase
      end
      default: begin
        pd_type = 4'd0;
        pd_op   = 6'd0;
      end
    endcase
  end

  logic do_push, do_pop;
  assign do_push = (state == WAIT) && mc_to_if_ready;
  assign do_pop  = (count != '0) && !rob_full && !rs_full;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      if_to_mc_en     <= 1'b0;
      if_to_mc_PC     <= 32'd0;
      if_to_dc_ready  <= 1'b0;
      if_to_dc_PC     <= 32'd0;
      if_to_dc_inst   <= 32'd0;
      if_to_dc_opType <= 4'd0;
      if_to_dc_op     <= 6'd0;
    end else if (!rdy_in) begin
      if_to_dc_ready <= 1'b0;
    end else if (rob_to_if_jump_en) begin
      pc             <= rob_to_if_jump_addr;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      if_to_mc_en    <= 1'b0;
      if_to_dc_ready <= 1'b0;
      // A response still owed by memory must be swallowed before refetching,
      // otherwise it would be mistaken for the new PC's word.
      if ((state == WAIT || state == DISCARD) && !mc_to_if_ready)
        state <= DISCARD;
      else
        state <= IDLE;
    end else begin
      if (do_push) begin
        iq_pc[tail]   <= pc;
        iq_inst[tail] <= mc_to_if_inst;
        iq_type[tail] <= pd_type;
        iq_op[tail]   <= pd_op;
        tail          <= tail + PW'(1);
      end

      if (do_pop) begin
        if_to_dc_ready  <= 1'b1;
        if_to_dc_PC     <= iq_pc[head];
        if_to_dc_inst   <= iq_inst[head];
        if_to_dc_opType <= iq_type[head];
        if_to_dc_op     <= iq_op[head];
        head            <= head + PW'(1);
      end else begin
        if_to_dc_ready <= 1'b0;
      end

      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          // Only one request is ever in flight, so a free slot now is the
          // slot reserved for its response.
          if (count != IQ_FULL) begin
            if_to_mc_en <= 1'b1;
            if_to_mc_PC <= pc;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (mc_to_if_ready) begin
            if_to_mc_en <= 1'b0;
            pc          <= next_pc;
            state       <= IDLE;
          end
        end
        DISCARD: begin
          if_to_mc_en <= 1'b0;
          if (mc_to_if_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  localparam logic [3:0] T_LUI = 4'd1, T_AUIPC = 4'd2, T_JAL = 4'd3, T_JALR = 4'd4,
                         T_BR = 4'd5, T_LD = 4'd6, T_ST = 4'd7, T_RI = 4'd8, T_RC = 4'd9;
  localparam logic [5:0] O_LUI = 6'd1, O_AUIPC = 6'd2, O_JAL = 6'd3, O_JALR = 6'd4,
                         O_BEQ = 6'd5, O_LW = 6'd13, O_SW = 6'd18, O_ADDI = 6'd19,
                         O_SRAI = 6'd27, O_SUB = 6'd29;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        rob_full = 1'b0;
  logic        rs_full = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = 32'd0;
  logic        mc_ready = 1'b0;
  logic [31:0] mc_inst = 32'd0;

  logic        if_to_mc_en;
  logic [31:0] if_to_mc_PC;
  logic        if_to_dc_ready;
  logic [31:0] if_to_dc_PC;
  logic [31:0] if_to_dc_inst;
  logic [3:0]  if_to_dc_opType;
  logic [5:0]  if_to_dc_op;

  always #5 clk = ~clk;

  ifetch_unit #(.IQ_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_in              (clk),
    .rst_in              (rst_n),
    .rdy_in              (rdy),
    .rob_full            (rob_full),
    .rs_full             (rs_full),
    .rob_to_if_jump_en   (jump_en),
    .rob_to_if_jump_addr (jump_addr),
    .if_to_mc_en         (if_to_mc_en),
    .if_to_mc_PC         (if_to_mc_PC),
    .mc_to_if_ready      (mc_ready),
    .mc_to_if_inst       (mc_inst),
    .if_to_dc_ready      (if_to_dc_ready),
    .if_to_dc_PC         (if_to_dc_PC),
    .if_to_dc_inst       (if_to_dc_inst),
    .if_to_dc_opType     (if_to_dc_opType),
    .if_to_dc_op         (if_to_dc_op)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [3:0]  opt;
    logic [5:0]  op;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   disp_cnt = 0;

  // Program image with hand-decoded classification of each word.
  function automatic exp_t mem_entry(input logic [31:0] a);
    exp_t e;
    case (a)
      32'h000: e = '{a, 32'h00500093, T_RI,    O_ADDI};
      32'h004: e = '{a, 32'h40208133, T_RC,    O_SUB};
      32'h008: e = '{a, 32'h0000A183, T_LD,    O_LW};
      32'h00C: e = '{a, 32'h00312223, T_ST,    O_SW};
      32'h010: e = '{a, 32'h12345137, T_LUI,   O_LUI};
      32'h014: e = '{a, 32'h4020D093, T_RI,    O_SRAI};
      32'h018: e = '{a, 32'h00208463, T_BR,    O_BEQ};
      32'h01C: e = '{a, 32'h00000117, T_AUIPC, O_AUIPC};
      32'h100: e = '{a, 32'hFFFFFFFF, 4'd0,    6'd0};
      32'h104: e = '{a, 32'h0100006F, T_JAL,   O_JAL};
      32'h114: e = '{a, 32'h000080E7, T_JALR,  O_JALR};
      default: e = '{a, 32'h00000013, T_RI,    O_ADDI};
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Dispatch monitor / scoreboard consumer
  always @(negedge clk) begin
    if (if_to_dc_ready === 1'b1) begin
      exp_t e;
      disp_cnt++;
      check("dispatch_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("dc_pc",     64'(if_to_dc_PC),     64'(e.pc));
        check("dc_inst",   64'(if_to_dc_inst),   64'(e.inst));
        check("dc_opType", 64'(if_to_dc_opType), 64'(e.opt));
        check("dc_op",     64'(if_to_dc_op),     64'(e.op));
      end
    end
  end

  task automatic wait_req(input logic [31:0] exp_pc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if_to_mc_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("req_seen", 64'(ok), 64'd1);
    if (ok) check("req_pc", 64'(if_to_mc_PC), 64'(exp_pc));
  endtask

  // Serve one request at address a after lat cycles; queue the expected
  // dispatch only when it must survive to decode.
  task automatic fetch(input logic [31:0] a, input int lat, input bit disp);
    bit   ok;
    exp_t e;
    wait_req(a, ok);
    if (!ok) return;
    e = mem_entry(a);
    repeat (lat - 1) @(negedge clk);
    check("req_held", {31'd0, if_to_mc_en, if_to_mc_PC}, {31'd0, 1'b1, a});
    mc_ready = 1'b1;
    mc_inst  = e.inst;
    if (disp) sb.push_back(e);
    @(negedge clk);
    mc_ready = 1'b0;
    mc_inst  = 32'd0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    bit          seen;
    int          d0;
    logic        s_en;
    logic [31:0] s_pc;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mc_en",   64'(if_to_mc_en),     64'd0);
    check("rst_mc_pc",   64'(if_to_mc_PC),     64'd0);
    check("rst_dc_rdy",  64'(if_to_dc_ready),  64'd0);
    check("rst_dc_pc",   64'(if_to_dc_PC),     64'd0);
    check("rst_dc_inst", 64'(if_to_dc_inst),   64'd0);
    check("rst_dc_type", 64'(if_to_dc_opType), 64'd0);
    check("rst_dc_op",   64'(if_to_dc_op),     64'd0);
    rst_n = 1'b1;

    // First fetch: ADDI at 0, memory latency 3, dispatched one cycle after push
    fetch(32'h0, 3, 1'b1);
    @(negedge clk);
    check("fetch_to_dispatch", 64'(if_to_dc_ready), 64'd1);
    wait_req(32'h4, ok);
    repeat (2) @(negedge clk);
    check("first_disp_cnt", 64'(disp_cnt), 64'd1);

    // Fill the queue under a ROB stall
    rst_n = 1'b0;
    rob_full = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    fetch(32'h0, 2, 1'b1);
    fetch(32'h4, 2, 1'b1);
    fetch(32'h8, 2, 1'b1);
    fetch(32'hC, 2, 1'b1);
    d0 = disp_cnt;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if_to_mc_en !== 1'b0 || if_to_dc_ready !== 1'b0) seen = 1'b1;
    end
    check("full_quiet", 64'(seen), 64'd0);
    check("full_no_disp", 64'(disp_cnt), 64'(d0));
    rob_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_back_to_back", 64'(if_to_dc_ready), 64'd1);
    end
    fetch(32'h10, 1, 1'b1);
    fetch(32'h14, 2, 1'b1);

    // Redirect while waiting for 0x20, with 0x18/0x1C still queued
    repeat (2) @(negedge clk);
    rob_full = 1'b1;
    fetch(32'h18, 1, 1'b0);
    fetch(32'h1C, 2, 1'b0);
    wait_req(32'h20, ok);
    jump_en   = 1'b1;
    jump_addr = 32'h100;
    @(negedge clk);
    jump_en  = 1'b0;
    rob_full = 1'b0;
    check("redir_mc_en", 64'(if_to_mc_en), 64'd0);
    check("redir_dc_rdy", 64'(if_to_dc_ready), 64'd0);
    @(negedge clk);
    check("discard_mc_en", 64'(if_to_mc_en), 64'd0);
    mc_ready = 1'b1;
    mc_inst  = 32'h00500093;
    @(negedge clk);
    mc_ready = 1'b0;
    mc_inst  = 32'd0;
    fetch(32'h100, 2, 1'b1);

    // JAL at 0x104 jumps to 0x114; JALR is not predicted
    fetch(32'h104, 3, 1'b1);
    fetch(32'h114, 1, 1'b1);

    // Freeze with two queued words
    repeat (2) @(negedge clk);
    rs_full = 1'b1;
    fetch(32'h118, 2, 1'b1);
    fetch(32'h11C, 2, 1'b1);
    @(negedge clk);
    rdy = 1'b0;
    rs_full = 1'b0;
    s_en = if_to_mc_en;
    s_pc = if_to_mc_PC;
    check("freeze_req", {31'd0, s_en, s_pc}, {31'd0, 1'b1, 32'h120});
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (if_to_dc_ready !== 1'b0 || if_to_mc_en !== s_en || if_to_mc_PC !== s_pc)
        seen = 1'b1;
    end
    check("freeze_hold", 64'(seen), 64'd0);
    rdy = 1'b1;
    @(negedge clk);
    check("thaw_disp0", 64'(if_to_dc_ready), 64'd1);
    @(negedge clk);
    check("thaw_disp1", 64'(if_to_dc_ready), 64'd1);
    fetch(32'h120, 1, 1'b1);

    // Reset mid-request with three queued words, late response afterwards
    repeat (2) @(negedge clk);
    rob_full = 1'b1;
    fetch(32'h124, 1, 1'b0);
    fetch(32'h128, 1, 1'b0);
    fetch(32'h12C, 1, 1'b0);
    wait_req(32'h130, ok);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_mc_en",   64'(if_to_mc_en),     64'd0);
    check("mid_rst_mc_pc",   64'(if_to_mc_PC),     64'd0);
    check("mid_rst_dc_rdy",  64'(if_to_dc_ready),  64'd0);
    check("mid_rst_dc_pc",   64'(if_to_dc_PC),     64'd0);
    check("mid_rst_dc_inst", 64'(if_to_dc_inst),   64'd0);
    check("mid_rst_dc_type", 64'(if_to_dc_opType), 64'd0);
    check("mid_rst_dc_op",   64'(if_to_dc_op),     64'd0);
    rst_n    = 1'b1;
    mc_ready = 1'b1;
    mc_inst  = 32'h00500093;
    @(negedge clk);
    mc_ready = 1'b0;
    mc_inst  = 32'd0;
    rob_full = 1'b0;
    check("rst_restart", {31'd0, if_to_mc_en, if_to_mc_PC}, {31'd0, 1'b1, 32'h0});
    fetch(32'h0, 2, 1'b1);

    repeat (4) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("dispatch_total", 64'(disp_cnt), 64'd14);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
